// File: rtl/fifo_stat.sv
// Synchronous FIFO with occupancy count, almost-empty/almost-full thresholds,
// sticky overflow/underflow flags and a synchronous flush.
module fifo_stat #(
    parameter int B      = 8,
    parameter int W      = 4,
    parameter int AE_THR = 1,
    parameter int AF_THR = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};
    localparam logic [W:0] AE_L  = (W+1)'(AE_THR);
    localparam logic [W:0] AF_L  = (W+1)'(AF_THR);

    logic [B-1:0] mem_q [2**W];
    logic [W-1:0] w_ptr_q, w_ptr_d;
    logic [W-1:0] r_ptr_q, r_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         ae_q, ae_d;
    logic         af_q, af_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic         wa, ra, mem_we;

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        wa      = wr & (~full_q | rd);
        ra      = rd & ~empty_q;
        mem_we  = wa & ~clr;
        w_ptr_d = w_ptr_q + W'(wa);
        r_ptr_d = r_ptr_q + W'(ra);
        count_d = count_q + (W+1)'(wa) - (W+1)'(ra);
        ovf_d   = ovf_q | (wr & ~wa);
        udf_d   = udf_q | (rd & ~ra);
        if (clr) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end
        // Flags come from the next count so they move on the causing edge.
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH);
        ae_d    = (count_d <= AE_L);
        af_d    = (count_d >= AF_L);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= (AF_L == '0);
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count alone define which words are valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[w_ptr_q] <= w_data;
        end
    end

    assign r_data       = mem_q[r_ptr_q];
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: doc/fifo_stat.md
# fifo_stat

Parametrised synchronous FIFO for the UART datapath, succeeding the plain receive FIFO. It adds a full output, an occupancy count, programmable almost-empty/almost-full thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between the UART RX/TX engines and the CPU-side bus interface, and it is instantiated once per direction.

## Interface
- B, 8, data word width in bits
- W, 4, address width; depth is 2**W words
- AE_THR, 1, almost_empty asserts when count <= AE_THR
- AF_THR, 14, almost_full asserts when count >= AF_THR; legal range is 0 <= AE_THR < AF_THR <= 2**W
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush, highest priority after reset
- wr  in  1  write request
- rd  in  1  read request; pops the head word
- w_data  in  B  write data
- r_data  out  B  head word (show-ahead); don't-care while empty
- empty  out  1  count == 0
- full  out  1  count == 2**W
- almost_empty  out  1  count <= AE_THR
- almost_full  out  1  count >= AF_THR
- count  out  W+1  occupancy, range 0..2**W
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage is a 2**W x B register array that is not reset. Write pointer and read pointer are each W bits and wrap modulo 2**W naturally.
- r_data = array[r_ptr], combinational from the registered read pointer.
- Write acceptance: wa = wr & (~full | rd).
- Read acceptance: ra = rd & ~empty.
- Accepted write: array[w_ptr] <= w_data, then w_ptr increments.
- Accepted read: r_ptr increments.
- count_next = count + wa - ra, computed at W+1 bits with no wrap.
- All four status flags are registered and derived from count_next. They change on the same edge as the operation that causes the change.
- Simultaneous events:
  - empty, wr & rd: write accepted, read rejected, underflow set, count becomes 1.
  - full, wr & rd: both accepted (pass-through slot), count stays 2**W, full stays 1.
  - partial fill, wr & rd: both accepted, count unchanged.
- Rejected write (wr & full & ~rd): array and pointers unchanged, overflow <= 1.
- Rejected read (rd & empty): no state change except underflow <= 1.
- overflow and underflow stay set until reset or clr.
- clr = 1:
  - w_ptr, r_ptr and count go to 0; empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THR == 0 ? 1 : 0).
  - overflow and underflow are cleared.
  - rd and wr are ignored that cycle.
  - array contents are untouched.
- reset: same values as clr, applied asynchronously. A reset mid-operation discards all queued data logically.
- No state machine beyond pointer/count registers; behaviour is fully defined by the rules above.

## Timing
- Reset values: count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for AF_THR > 0), overflow = 0, underflow = 0, r_data = X.
- Write-to-read latency is 1 cycle. A word written at edge N into an empty FIFO appears on r_data, with empty = 0, after edge N.
- Read: rd is sampled at edge N; the next word appears on r_data after edge N. The consumer uses r_data in the same cycle it asserts rd.
- Flags, count and sticky bits are all registered. There is no combinational path from wr/rd to any output; r_data depends only on the pointer register and the array.
- Throughput is one write and one read per cycle, sustained.

## Test plan
- B=8, W=2, AE_THR=1, AF_THR=3:
  - Reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count goes 1, 2, 3, 4. almost_empty drops after the 2nd write, almost_full rises after the 3rd, full rises after the 4th, and r_data = 0x11 throughout.
  - Full FIFO, wr with 0x55 -> count stays 4, overflow = 1, contents unchanged. Then read 4 words -> r_data shows 0x11, 0x22, 0x33, 0x44, then empty = 1, with overflow still 1.
  - Empty FIFO, rd alone -> underflow = 1, count 0. Then wr & rd with 0x66 -> count 1, r_data = 0x66, underflow still 1.
  - Full FIFO, wr & rd with 0x77 for 4 cycles -> count stays 4, full stays 1. After draining, output order is the last four words, ending in 0x77, 0x77, 0x77, 0x77.
  - Pointer wrap: 10 cycles of alternate single write/read with values 0x00..0x09 -> each value read back in order, count toggles 1/0, no error flags set.
  - Fill with 3 words, pulse clr (with wr also high) -> next cycle count = 0, empty = 1, sticky bits = 0. Assert reset asynchronously mid-write -> outputs take reset values before the next clk edge.
